param_shift_sequencer: RTL and testbench
========================================

Name: param_shift_sequencer

Overview:
- Parametrised universal shift register with built-in serial sequence generation.
- Modes: hold, shift left/right, parallel load, rotate left/right, Fibonacci LFSR, and a programmable-length pattern generator with a wrap pulse.
- Replaces fixed 4-bit shift registers and hard-coded sequence FSMs in the lab datapath.
- Feeds serial links and test-pattern sources.

Parameters:
WIDTH, 8, register width in bits (>=2)
LW, $clog2(WIDTH)+1, width of seq_len (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  advance enable; 0 = all state holds
mode  input  3  operation select (see Behaviour)
ser_in_r  input  1  bit shifted into MSB on shift-right
ser_in_l  input  1  bit shifted into LSB on shift-left
load_data  input  WIDTH  parallel load value
taps  input  WIDTH  LFSR feedback tap mask
seq_len  input  LW  pattern length L for pattern mode
q  output  WIDTH  register contents
ser_out  output  1  serial output
wrap  output  1  one-cycle pulse after pattern wrap
zero  output  1  q == 0

Behaviour:
- Reset (async, rst_n=0): q=0, pos=0, wrap=0. Consequently ser_out=0 and zero=1. Reset overrides everything, including mid-pattern.
- All updates occur on the rising clk edge when en=1.
- When en=0: q and pos hold, and wrap is registered 0.
- Mode codes:
  - 000 HOLD: q holds.
  - 001 SHR: q <= {ser_in_r, q[WIDTH-1:1]}.
  - 010 SHL: q <= {q[WIDTH-2:0], ser_in_l}.
  - 011 LOAD: q <= load_data.
  - 100 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 101 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 110 LFSR:
    - fb = XOR-reduce(q & taps); q <= {q[WIDTH-2:0], fb}.
    - Lock-up escape: if q==0, q <= 1 instead.
  - 111 PAT:
    - Effective length Le = WIDTH if seq_len==0 or seq_len>WIDTH; otherwise Le = seq_len.
    - Bits [Le-1:0] rotate right: q[i] <= q[i+1] for i<Le-1, and q[Le-1] <= q[0].
    - Bits [WIDTH-1:Le] hold.
    - Le=1: q holds.
- ser_out is combinational: q[WIDTH-1] when mode is SHL, ROL or LFSR; q[0] for all other modes.
- zero is combinational: (q == 0).
- Position counter pos, range 0..WIDTH-1:
  - When en=1 and mode!=PAT: pos <= 0.
  - When en=1 and mode==PAT: if pos >= Le-1, pos <= 0 and wrap <= 1; otherwise pos <= pos+1 and wrap <= 0.
  - wrap is registered: high for exactly the cycle after the Le-th advance.
  - Le=1: wrap is high on every enabled PAT cycle.
- Mode changes take effect at the next edge. There is no pipeline; latency is 1 cycle from inputs to q.
- Entering PAT from another mode starts pos at 0, because non-PAT cycles clear it.
- Changing seq_len mid-pattern to a value with pos >= Le-1 forces an immediate wrap on the next enabled edge.
- LOAD during PAT (mode switch) clears pos. The loaded pattern restarts on the next PAT cycle.
- Widths: no arithmetic overflow paths.
  - pos compare uses LW bits.
  - seq_len is compared unsigned.

Decomposition:
- Package pss_pkg holds:
  - mode localparams MODE_HOLD..MODE_PAT (3-bit);
  - a function for clamping the effective length.
- One sub-module, pss_wrap_counter (pos counter plus registered wrap). Inputs: clk, rst_n, advance, clear, le. Output: wrap.
- Next-state mux stays in the top module.

Test Plan (WIDTH=8):
1. Reset and hold:
   - Assert rst_n=0 mid-cycle with q=8'hFF -> q=00, wrap=0, zero=1 immediately.
   - With en=0 and any mode for 5 cycles -> q unchanged.
2. Load and right shift:
   - LOAD 8'hA5, then SHR twice with ser_in_r=1 -> q=A5, D2, E9.
   - ser_out follows q[0]: 1, 0, 1.
3. Left shift and rotates:
   - From 8'h81, SHL with ser_in_l=0 -> 02.
   - From 8'h81, ROL -> 03.
   - From 8'h81, ROR -> C0; a second ROR -> 60.
4. Pattern mode:
   - LOAD 8'h32, seq_len=6, PAT for 12 cycles -> ser_out sequence 0,1,0,0,1,1,0,1,0,0,1,1.
   - wrap high in the cycle after advances 6 and 12 only.
   - q[7:6] stay 00.
   - seq_len=0 gives period 8.
5. LFSR:
   - taps=8'hB8 starting from q=00 -> first step q=01.
   - q returns to 01 after a further 255 steps.
   - zero is never 1 during the run.
6. Mid-operation events:
   - Reset asserted at pos=3 in PAT -> q=0, pos=0, no wrap.
   - seq_len changed 6->2 at pos=4 -> wrap on the next edge, then period 2.

Source files
------------

// File: rtl/pss_pkg.sv
// Shared definitions for the parametrised shift sequencer: mode codes and
// the pattern-length clamp used by the datapath and the wrap counter.
package pss_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_LFSR = 3'b110;
    localparam logic [2:0] MODE_PAT  = 3'b111;

    // A length of zero, or one longer than the register, means "use the whole register".
    function automatic int unsigned eff_len(input int unsigned seq_len,
                                            input int unsigned width);
        if ((seq_len == 0) || (seq_len > width)) begin
            return width;
        end
        return seq_len;
    endfunction

endpackage

// File: rtl/pss_wrap_counter.sv
// Pattern position counter with a registered wrap pulse that fires in the
// cycle after the advance that completes one pattern period.
module pss_wrap_counter #(
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    input  logic          clear,
    input  logic [LW-1:0] le,
    output logic          wrap
);

    logic [LW-1:0] pos_q, pos_d;
    logic          wrap_q, wrap_d;

    always_comb begin
        pos_d  = pos_q;
        wrap_d = 1'b0;
        if (clear) begin
            pos_d = '0;
        end else if (advance) begin
            // le is never zero, so le-1 cannot underflow; a shrunk length wraps at once.
            if (pos_q >= (le - LW'(1))) begin
                pos_d  = '0;
                wrap_d = 1'b1;
            end else begin
                pos_d = pos_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: rtl/param_shift_sequencer.sv
// Universal shift register with rotate, Fibonacci LFSR and a
// programmable-length rotating pattern generator.
module param_shift_sequencer
    import pss_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] taps,
    input  logic [LW-1:0]    seq_len,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             wrap,
    output logic             zero
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] pat_next;
    logic [LW-1:0]    le;
    logic [LW-1:0]    le_top;
    logic             fb;
    logic             pat_advance;
    logic             pat_clear;

    assign le     = LW'(eff_len(32'(seq_len), WIDTH));
    assign le_top = le - LW'(1);
    assign fb     = ^(q_q & taps);

    // Bits below le rotate right within the window, bits above it hold.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pat
            if (gi < WIDTH - 1) begin : g_inner
                assign pat_next[gi] = (LW'(gi) < le_top)  ? q_q[gi+1] :
                                      (LW'(gi) == le_top) ? q_q[0]    : q_q[gi];
            end else begin : g_msb
                assign pat_next[gi] = (LW'(gi) == le_top) ? q_q[0] : q_q[gi];
            end
        end
    endgenerate

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_SHR:  q_d = {ser_in_r, q_q[WIDTH-1:1]};
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], ser_in_l};
                MODE_LOAD: q_d = load_data;
                MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_LFSR: q_d = (q_q == '0) ? WIDTH'(1) : {q_q[WIDTH-2:0], fb};
                MODE_PAT:  q_d = pat_next;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign pat_advance = en && (mode == MODE_PAT);
    assign pat_clear   = en && (mode != MODE_PAT);

    pss_wrap_counter #(
        .LW(LW)
    ) u_wrap_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .advance(pat_advance),
        .clear  (pat_clear),
        .le     (le),
        .wrap   (wrap)
    );

    // Left-moving modes emit the MSB; everything else emits the LSB.
    assign ser_out = ((mode == MODE_SHL) || (mode == MODE_ROL) || (mode == MODE_LFSR)) ?
                     q_q[WIDTH-1] : q_q[0];
    assign zero    = (q_q == '0);
    assign q       = q_q;

endmodule

// File: tb/tb_param_shift_sequencer.sv
// Directed bench for param_shift_sequencer (WIDTH=8) with a behavioural
// reference model compared on every falling clock edge.
module tb_param_shift_sequencer;

    localparam int W  = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [2:0]    mode;
    logic          ser_in_r;
    logic          ser_in_l;
    logic [W-1:0]  load_data;
    logic [W-1:0]  taps;
    logic [LW-1:0] seq_len;
    logic [W-1:0]  q;
    logic          ser_out;
    logic          wrap;
    logic          zero;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [W-1:0] m_q;
    int           m_pos;
    logic         m_wrap;

    param_shift_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .ser_in_r (ser_in_r),
        .ser_in_l (ser_in_l),
        .load_data(load_data),
        .taps     (taps),
        .seq_len  (seq_len),
        .q        (q),
        .ser_out  (ser_out),
        .wrap     (wrap),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int model_len(input logic [LW-1:0] sl);
        if (sl == 0 || int'(sl) > W) return W;
        return int'(sl);
    endfunction

    // Behavioural model: derived from the mode rules with plain arithmetic.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q = '0; m_pos = 0; m_wrap = 1'b0;
        end else if (!en) begin
            m_wrap = 1'b0;
        end else begin
            logic [W-1:0] t;
            int le;
            t  = m_q;
            le = model_len(seq_len);
            m_wrap = 1'b0;
            case (mode)
                3'd1: m_q = (t >> 1) | (W'(ser_in_r) << (W-1));
                3'd2: m_q = (t << 1) | W'(ser_in_l);
                3'd3: m_q = load_data;
                3'd4: m_q = (t >> 1) | (t << (W-1));
                3'd5: m_q = (t << 1) | (t >> (W-1));
                3'd6: begin
                    if (t == 0) m_q = 1;
                    else m_q = (t << 1) | W'($countones(t & taps) % 2);
                end
                3'd7: begin
                    for (int i = 0; i < le; i++) m_q[i] = t[(i + 1) % le];
                end
                default: m_q = t;
            endcase
            if (mode == 3'd7) begin
                m_pos = m_pos + 1;
                if (m_pos >= le) begin
                    m_pos  = 0;
                    m_wrap = 1'b1;
                end
            end else begin
                m_pos = 0;
            end
        end
    end

    // Compare process: all outputs are meaningful on every cycle.
    always @(negedge clk) begin
        logic exp_ser;
        exp_ser = (mode == 3'd2 || mode == 3'd5 || mode == 3'd6) ? m_q[W-1] : m_q[0];
        check("cmp_q", 32'(q), 32'(m_q));
        check("cmp_wrap", 32'(wrap), 32'(m_wrap));
        check("cmp_ser", 32'(ser_out), 32'(exp_ser));
        check("cmp_zero", 32'(zero), 32'(m_q == 0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic e, input logic [2:0] m);
        en = e; mode = m;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        set(1'b1, 3'd3); load_data = v;
        tick();
    endtask

    initial begin
        int  exp_seq [12] = '{0,1,0,0,1,1,0,1,0,0,1,1};
        bit  saw_zero;

        rst_n = 1'b0; en = 1'b0; mode = 3'd0; ser_in_r = 1'b0; ser_in_l = 1'b0;
        load_data = '0; taps = '0; seq_len = '0;
        repeat (3) tick();
        check("rst_q", 32'(q), 32'h00);
        check("rst_zero", 32'(zero), 32'h1);
        check("rst_ser", 32'(ser_out), 32'h0);
        rst_n = 1'b1;

        // 1. mid-cycle reset and hold
        do_load(8'hFF);
        check("load_ff", 32'(q), 32'hFF);
        #2; rst_n = 1'b0; #1;
        check("async_rst_q", 32'(q), 32'h00);
        check("async_rst_zero", 32'(zero), 32'h1);
        check("async_rst_wrap", 32'(wrap), 32'h0);
        tick(); rst_n = 1'b1;
        do_load(8'h5A);
        for (int i = 0; i < 5; i++) begin
            set(1'b0, 3'(i + 1));
            tick();
            check("hold_en0", 32'(q), 32'h5A);
        end

        // 2. load and right shift
        do_load(8'hA5);
        check("load_a5", 32'(q), 32'hA5);
        check("ser_a5", 32'(ser_out), 32'h1);
        set(1'b1, 3'd1); ser_in_r = 1'b1;
        tick();
        check("shr1", 32'(q), 32'hD2);
        check("ser_d2", 32'(ser_out), 32'h0);
        tick();
        check("shr2", 32'(q), 32'hE9);
        check("ser_e9", 32'(ser_out), 32'h1);

        // 3. left shift and rotates
        do_load(8'h81); set(1'b1, 3'd2); ser_in_l = 1'b0; tick();
        check("shl", 32'(q), 32'h02);
        do_load(8'h81); set(1'b1, 3'd5); tick();
        check("rol", 32'(q), 32'h03);
        do_load(8'h81); set(1'b1, 3'd4); tick();
        check("ror1", 32'(q), 32'hC0);
        tick();
        check("ror2", 32'(q), 32'h60);

        // 4. pattern mode, length 6
        seq_len = 4'd6;
        do_load(8'h32);
        set(1'b1, 3'd7);
        for (int k = 1; k <= 12; k++) begin
            check("pat_ser", 32'(ser_out), 32'(exp_seq[k-1]));
            tick();
            check("pat_wrap", 32'(wrap), 32'((k == 6) || (k == 12)));
            check("pat_msbs", 32'(q[7:6]), 32'h0);
        end
        // length 0 -> full width
        seq_len = 4'd0;
        do_load(8'h01);
        set(1'b1, 3'd7);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("pat8_wrap", 32'(wrap), 32'(k == 8));
        end
        check("pat8_q", 32'(q), 32'h01);
        // length beyond width also clamps to full width
        seq_len = 4'd9;
        do_load(8'h03);
        set(1'b1, 3'd7);
        repeat (8) tick();
        check("pat9_q", 32'(q), 32'h03);

        // 5. LFSR lock-up escape and period
        taps = 8'hB8;
        do_load(8'h00);
        set(1'b1, 3'd6); tick();
        check("lfsr_first", 32'(q), 32'h01);
        saw_zero = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (zero) saw_zero = 1'b1;
            if (k < 255 && q == 8'h01) saw_zero = 1'b1;
        end
        check("lfsr_period", 32'(q), 32'h01);
        check("lfsr_nozero_noearly", 32'(saw_zero), 32'h0);

        // 6a. reset at pos=3 in PAT
        seq_len = 4'd6;
        do_load(8'h32);
        set(1'b1, 3'd7);
        repeat (3) tick();
        #2; rst_n = 1'b0; #1;
        check("pat_rst_q", 32'(q), 32'h00);
        check("pat_rst_wrap", 32'(wrap), 32'h0);
        tick(); rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("post_rst_wrap", 32'(wrap), 32'(k == 6));
        end

        // 6b. shrink seq_len 6->2 at pos=4
        do_load(8'h32);
        set(1'b1, 3'd7);
        repeat (4) tick();
        check("pre_shrink_wrap", 32'(wrap), 32'h0);
        seq_len = 4'd2;
        tick();
        check("shrink_wrap", 32'(wrap), 32'h1);
        tick();
        check("shrink_p2a", 32'(wrap), 32'h0);
        tick();
        check("shrink_p2b", 32'(wrap), 32'h1);

        set(1'b0, 3'd0);
        tick();
        check("en0_wrap", 32'(wrap), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
